// File: rtl/tug_playfield.sv
// Tug-of-war rope controller: one lit LED moves one step per fresh key press.
// A press at either end declares a winner and freezes the rope until restartGame.
module tug_playfield #(
   parameter int LIGHTS = 9
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              L,
   input  logic              R,
   input  logic              restartGame,
   output logic [LIGHTS-1:0] LEDR,
   output logic              LED1,
   output logic              LED9,
   output logic              p1Win,
   output logic              p2Win
);

   localparam int CTR = (LIGHTS + 1) / 2;
   localparam int PW  = $clog2(LIGHTS + 1);

   localparam logic [PW-1:0]     POS_MIN  = PW'(1);
   localparam logic [PW-1:0]     POS_MAX  = PW'(LIGHTS);
   localparam logic [PW-1:0]     POS_CTR  = PW'(CTR);
   localparam logic [LIGHTS-1:0] LEDR_CTR = LIGHTS'(1) << (CTR - 1);

   typedef enum logic [1:0] {
      PLAY,
      WIN1,
      WIN2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PW-1:0]     pos;
   logic [PW-1:0]     pos_nxt;
   logic [LIGHTS-1:0] ledr_nxt;
   logic              p1_win_nxt;
   logic              p2_win_nxt;
   logic              l_prev;
   logic              r_prev;
   logic              press_l;
   logic              press_r;

   // Previous samples reset high so a key held through reset release is not a press.
   assign press_l = L & ~l_prev;
   assign press_r = R & ~r_prev;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= PLAY;
         pos    <= POS_CTR;
         LEDR   <= LEDR_CTR;
         p1Win  <= 1'b0;
         p2Win  <= 1'b0;
         l_prev <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         state  <= state_nxt;
         pos    <= pos_nxt;
         LEDR   <= ledr_nxt;
         p1Win  <= p1_win_nxt;
         p2Win  <= p2_win_nxt;
         l_prev <= L;
         r_prev <= R;
      end
   end

   always_comb begin
      state_nxt  = state;
      pos_nxt    = pos;
      p1_win_nxt = 1'b0;
      p2_win_nxt = 1'b0;
      unique case (state)
         PLAY: begin
            if (restartGame) begin
               pos_nxt = POS_CTR;
            end else if (press_l && press_r) begin
               pos_nxt = pos;
            end else if (press_r && pos == POS_MIN) begin
               state_nxt  = WIN1;
               p1_win_nxt = 1'b1;
            end else if (press_l && pos == POS_MAX) begin
               state_nxt  = WIN2;
               p2_win_nxt = 1'b1;
            end else if (press_r) begin
               pos_nxt = pos - POS_MIN;
            end else if (press_l) begin
               pos_nxt = pos + POS_MIN;
            end
         end
         WIN1, WIN2: begin
            if (restartGame) begin
               pos_nxt   = POS_CTR;
               state_nxt = PLAY;
            end
         end
         default: begin
            state_nxt = PLAY;
            pos_nxt   = POS_CTR;
         end
      endcase
   end

   // LEDR is registered from the next position so a move shows one cycle after the key rises.
   always_comb begin
      ledr_nxt = '0;
      for (int unsigned i = 0; i < LIGHTS; i++) begin
         ledr_nxt[i] = (pos_nxt == PW'(i + 1));
      end
   end

   assign LED1 = LEDR[0];
   assign LED9 = LEDR[LIGHTS-1];

endmodule

// File: tb/tb_tug_playfield.sv
// Directed and randomized checks of tug_playfield against a game-rule model.
module tb_tug_playfield;

   localparam int N   = 9;
   localparam int CTR = (N + 1) / 2;

   logic         Clock;
   logic         Reset;
   logic         L;
   logic         R;
   logic         restartGame;
   logic [N-1:0] LEDR;
   logic         LED1;
   logic         LED9;
   logic         p1Win;
   logic         p2Win;

   int n_cmp;
   int n_bad;

   // Reference game state: rope position, winner (0 none, 1 right, 2 left), key history.
   int   m_pos;
   int   m_winner;
   bit   m_prev_l;
   bit   m_prev_r;
   bit   m_p1;
   bit   m_p2;

   tug_playfield #(.LIGHTS(N)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .L           (L),
      .R           (R),
      .restartGame (restartGame),
      .LEDR        (LEDR),
      .LED1        (LED1),
      .LED9        (LED9),
      .p1Win       (p1Win),
      .p2Win       (p2Win)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic model_reset();
      m_pos    = CTR;
      m_winner = 0;
      m_prev_l = 1'b1;
      m_prev_r = 1'b1;
      m_p1     = 1'b0;
      m_p2     = 1'b0;
   endtask

   task automatic model_edge(input bit l, input bit r, input bit rg);
      bit pl;
      bit pr;
      pl   = l && !m_prev_l;
      pr   = r && !m_prev_r;
      m_p1 = 1'b0;
      m_p2 = 1'b0;
      if (m_winner == 0) begin
         if (rg) m_pos = CTR;
         else if (pl && pr) m_pos = m_pos;
         else if (pr) begin
            if (m_pos == 1) begin m_winner = 1; m_p1 = 1'b1; end
            else m_pos = m_pos - 1;
         end else if (pl) begin
            if (m_pos == N) begin m_winner = 2; m_p2 = 1'b1; end
            else m_pos = m_pos + 1;
         end
      end else if (rg) begin
         m_pos    = CTR;
         m_winner = 0;
      end
      m_prev_l = l;
      m_prev_r = r;
   endtask

   task automatic check(input string tag);
      logic [N-1:0] exp;
      exp = '0;
      exp[m_pos-1] = 1'b1;
      n_cmp++;
      assert (LEDR === exp) else begin
         n_bad++;
         $error("FAIL %s LEDR observed=%b expected=%b", tag, LEDR, exp);
      end
      n_cmp++;
      assert (LED1 === exp[0]) else begin
         n_bad++;
         $error("FAIL %s LED1 observed=%b expected=%b", tag, LED1, exp[0]);
      end
      n_cmp++;
      assert (LED9 === exp[N-1]) else begin
         n_bad++;
         $error("FAIL %s LED9 observed=%b expected=%b", tag, LED9, exp[N-1]);
      end
      n_cmp++;
      assert (p1Win === m_p1) else begin
         n_bad++;
         $error("FAIL %s p1Win observed=%b expected=%b", tag, p1Win, m_p1);
      end
      n_cmp++;
      assert (p2Win === m_p2) else begin
         n_bad++;
         $error("FAIL %s p2Win observed=%b expected=%b", tag, p2Win, m_p2);
      end
   endtask

   task automatic check_ledr(input string tag, input logic [N-1:0] exp);
      n_cmp++;
      assert (LEDR === exp) else begin
         n_bad++;
         $error("FAIL %s LEDR observed=%b expected=%b", tag, LEDR, exp);
      end
   endtask

   task automatic step(input bit l, input bit r, input bit rg, input string tag);
      @(negedge Clock);
      L           = l;
      R           = r;
      restartGame = rg;
      @(posedge Clock);
      if (Reset) model_edge(l, r, rg);
      else model_reset();
      #1;
      check(tag);
   endtask

   task automatic press(input bit l, input bit r, input string tag);
      step(l, r, 1'b0, tag);
      step(1'b0, 1'b0, 1'b0, {tag, "_rel"});
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      Reset       = 1'b0;
      L           = 1'b0;
      R           = 1'b0;
      restartGame = 1'b0;
      model_reset();

      repeat (2) @(posedge Clock);
      #1;
      check("reset");
      check_ledr("reset_lit", 9'b000010000);
      @(negedge Clock);
      Reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, "idle");

      step(1'b0, 1'b1, 1'b0, "r_press");
      check_ledr("r_move", 9'b000001000);
      step(1'b0, 1'b0, 1'b0, "r_rel");
      step(1'b1, 1'b0, 1'b0, "l_press");
      check_ledr("l_move", 9'b000010000);
      step(1'b0, 1'b0, 1'b0, "l_rel");

      repeat (6) step(1'b0, 1'b1, 1'b0, "r_held");
      check_ledr("held_one_move", 9'b000001000);
      step(1'b0, 1'b0, 1'b0, "held_rel");
      press(1'b1, 1'b1, "both");
      check_ledr("both_no_move", 9'b000001000);

      step(1'b0, 1'b0, 1'b1, "restart");
      repeat (4) press(1'b0, 1'b1, "r_walk");
      check_ledr("r_end", 9'b000000001);
      step(1'b0, 1'b1, 1'b0, "r_win");
      step(1'b0, 1'b0, 1'b0, "r_win_after");
      press(1'b1, 1'b0, "win1_l_ign");
      press(1'b0, 1'b1, "win1_r_ign");
      check_ledr("win1_frozen", 9'b000000001);

      step(1'b0, 1'b0, 1'b1, "restart_w1");
      repeat (4) press(1'b1, 1'b0, "l_walk");
      check_ledr("l_end", 9'b100000000);
      press(1'b1, 1'b0, "l_win");
      step(1'b0, 1'b0, 1'b1, "restart_w2");
      check_ledr("restart_centre", 9'b000010000);
      press(1'b1, 1'b0, "l_after_restart");

      step(1'b0, 1'b0, 1'b1, "restart_c");
      repeat (2) press(1'b0, 1'b1, "to_pos3");
      step(1'b0, 1'b1, 1'b1, "restart_vs_r");
      check_ledr("restart_wins", 9'b000010000);
      step(1'b0, 1'b0, 1'b0, "restart_vs_r_rel");

      repeat (4) press(1'b1, 1'b0, "walk_w2");
      step(1'b1, 1'b0, 1'b0, "w2_pulse");
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      check("async_reset");
      repeat (2) step(1'b1, 1'b0, 1'b0, "rst_held");
      @(negedge Clock);
      Reset = 1'b1;
      repeat (3) step(1'b1, 1'b0, 1'b0, "l_held_release");
      step(1'b0, 1'b0, 1'b0, "l_rel_after_rst");

      for (int i = 0; i < 400; i++) begin
         bit rl;
         bit rr;
         bit rg;
         rl = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 2) == 0);
         rg = ($urandom_range(0, 24) == 0);
         step(rl, rr, rg, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
